// File: rtl/avl_multi_timer_if.sv
// ---------------------------------------------------------------------------
// avl_multi_timer_if
// Avalon-MM slave bus bundle for the multi-channel interval timer.
//   address    : {channel, register offset[2:0]}, CH_BITS+3 bits
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 16-bit write data
//   readdata   : 16-bit registered read data (driven by the slave)
// ---------------------------------------------------------------------------
interface avl_multi_timer_if #(
    parameter int CH_BITS = 2
);
    logic [CH_BITS+2:0] address;
    logic               chipselect;
    logic               write_n;
    logic [15:0]        writedata;
    logic [15:0]        readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avl_multi_timer.sv
// ---------------------------------------------------------------------------
// avl_multi_timer
// Multi-channel interval timer behind a 16-bit Avalon-MM slave port. Each
// channel has a period, a 16-bit prescaler, one-shot/continuous mode, a
// counter snapshot and an interrupt enable.
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata,
//              readdata); readdata is registered, one cycle after address
//   irq      : OR of irq_vec
//   irq_vec  : per-channel interrupt, timeout flag AND interrupt enable
//
// Per-channel register map (low three address bits):
//   0 status  R {running, TO}; any write clears TO
//   1 control R/W {CONT, ITO}; write bit2 START, bit3 STOP
//   2/3 period low/high half
//   4/5 snapshot low/high half; any write latches the counter
//   6 prescale divisor
//   7 pending interrupt vector (identical for every channel)
// ---------------------------------------------------------------------------
module avl_multi_timer #(
    parameter  int CH_BITS    = 2,
    parameter  int CNT_W      = 32,
    parameter  int DEF_PERIOD = 24999,
    localparam int NUM_CH     = 1 << CH_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    avl_multi_timer_if.slave    bus,
    output logic                irq,
    output logic [NUM_CH-1:0]   irq_vec
);

    localparam int AW = CH_BITS + 3;

    localparam logic [2:0] OFF_STATUS  = 3'd0;
    localparam logic [2:0] OFF_CONTROL = 3'd1;
    localparam logic [2:0] OFF_PER_L   = 3'd2;
    localparam logic [2:0] OFF_PER_H   = 3'd3;
    localparam logic [2:0] OFF_SNAP_L  = 3'd4;
    localparam logic [2:0] OFF_SNAP_H  = 3'd5;
    localparam logic [2:0] OFF_PRESC   = 3'd6;
    localparam logic [2:0] OFF_PEND    = 3'd7;

    // Upper 16 bits of a counter-width value, zero when CNT_W is 16.
    function automatic logic [15:0] hi16(input logic [CNT_W-1:0] v);
        return 16'(32'(v) >> 5'd16);
    endfunction

    // Lower 16 bits of a counter-width value.
    function automatic logic [15:0] lo16(input logic [CNT_W-1:0] v);
        return v[15:0];
    endfunction

    // Channel state
    logic [NUM_CH-1:0][CNT_W-1:0] period_q, period_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q,    cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] snap_q,   snap_d;
    logic [NUM_CH-1:0][15:0]      presc_q,  presc_d;
    logic [NUM_CH-1:0][15:0]      pcnt_q,   pcnt_d;
    logic [NUM_CH-1:0]            run_q,    run_d;
    logic [NUM_CH-1:0]            to_q,     to_d;
    logic [NUM_CH-1:0]            cont_q,   cont_d;
    logic [NUM_CH-1:0]            ito_q,    ito_d;
    logic [15:0]                  rdata_q,  rdata_d;

    // Decoded bus access and per-channel event strobes
    logic                         wr_s;
    logic [AW-1:0]                ch_s;
    logic [2:0]                   off_s;
    logic [15:0]                  wd_s;
    logic [NUM_CH-1:0]            sel_s;
    logic [NUM_CH-1:0]            wr_stat_s;
    logic [NUM_CH-1:0]            wr_ctrl_s;
    logic [NUM_CH-1:0]            wr_per_l_s;
    logic [NUM_CH-1:0]            wr_per_h_s;
    logic [NUM_CH-1:0]            wr_snap_s;
    logic [NUM_CH-1:0]            wr_presc_s;
    logic [NUM_CH-1:0]            start_s;
    logic [NUM_CH-1:0]            stop_s;
    logic [NUM_CH-1:0]            adv_s;
    logic [NUM_CH-1:0]            tick_s;
    logic [NUM_CH-1:0]            expire_s;

    // Address decode and per-channel write/tick/timeout strobes.
    always_comb begin
        wr_s       = bus.chipselect & ~bus.write_n;
        ch_s       = bus.address >> 3'd3;
        off_s      = bus.address[2:0];
        wd_s       = bus.writedata;
        sel_s      = {NUM_CH{1'b0}};
        wr_stat_s  = {NUM_CH{1'b0}};
        wr_ctrl_s  = {NUM_CH{1'b0}};
        wr_per_l_s = {NUM_CH{1'b0}};
        wr_per_h_s = {NUM_CH{1'b0}};
        wr_snap_s  = {NUM_CH{1'b0}};
        wr_presc_s = {NUM_CH{1'b0}};
        start_s    = {NUM_CH{1'b0}};
        stop_s     = {NUM_CH{1'b0}};
        adv_s      = {NUM_CH{1'b0}};
        tick_s     = {NUM_CH{1'b0}};
        expire_s   = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            sel_s[i]      = wr_s & (ch_s == AW'(i));
            wr_stat_s[i]  = sel_s[i] & (off_s == OFF_STATUS);
            wr_ctrl_s[i]  = sel_s[i] & (off_s == OFF_CONTROL);
            wr_per_l_s[i] = sel_s[i] & (off_s == OFF_PER_L);
            wr_per_h_s[i] = sel_s[i] & (off_s == OFF_PER_H);
            wr_snap_s[i]  = sel_s[i] & ((off_s == OFF_SNAP_L) | (off_s == OFF_SNAP_H));
            wr_presc_s[i] = sel_s[i] & (off_s == OFF_PRESC);
            // START dominates STOP when both bits are written together
            start_s[i]    = wr_ctrl_s[i] & wd_s[2];
            stop_s[i]     = wr_ctrl_s[i] & wd_s[3] & ~wd_s[2];
            // STOP and period writes freeze the count in their own cycle so
            // the held counter/prescaler values are exactly those seen by SW
            adv_s[i]      = run_q[i] & ~stop_s[i] & ~wr_per_l_s[i] & ~wr_per_h_s[i];
            tick_s[i]     = adv_s[i] & (pcnt_q[i] == 16'd0);
            expire_s[i]   = tick_s[i] & (cnt_q[i] == {CNT_W{1'b0}});
        end
    end

    // Next-state for every channel register.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        presc_d  = presc_q;
        pcnt_d   = pcnt_q;
        run_d    = run_q;
        to_d     = to_q;
        cont_d   = cont_q;
        ito_d    = ito_q;
        for (int i = 0; i < NUM_CH; i++) begin
            // Prescaler: reload on tick, otherwise count down while running
            if (start_s[i] | wr_per_l_s[i] | wr_per_h_s[i]) begin
                pcnt_d[i] = presc_q[i];
            end else if (tick_s[i]) begin
                pcnt_d[i] = presc_q[i];
            end else if (adv_s[i]) begin
                pcnt_d[i] = pcnt_q[i] - 16'd1;
            end else begin
                pcnt_d[i] = pcnt_q[i];
            end

            // Period halves; bits at CNT_W and above are dropped
            if (wr_per_l_s[i]) begin
                period_d[i]       = period_q[i];
                period_d[i][15:0] = wd_s;
            end else if (wr_per_h_s[i]) begin
                period_d[i] = CNT_W'({wd_s, period_q[i][15:0]});
            end else begin
                period_d[i] = period_q[i];
            end

            // Main counter
            if (wr_per_l_s[i] | wr_per_h_s[i]) begin
                cnt_d[i] = period_d[i];
            end else if (expire_s[i]) begin
                cnt_d[i] = period_q[i];
            end else if (tick_s[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end

            // Running flag; a period write forces SW to restart explicitly
            if (wr_per_l_s[i] | wr_per_h_s[i]) begin
                run_d[i] = 1'b0;
            end else if (start_s[i]) begin
                run_d[i] = 1'b1;
            end else if (stop_s[i]) begin
                run_d[i] = 1'b0;
            end else if (expire_s[i] & ~cont_q[i]) begin
                run_d[i] = 1'b0;
            end else begin
                run_d[i] = run_q[i];
            end

            // Timeout flag: a new event beats a simultaneous clear
            if (expire_s[i]) begin
                to_d[i] = 1'b1;
            end else if (wr_stat_s[i]) begin
                to_d[i] = 1'b0;
            end else begin
                to_d[i] = to_q[i];
            end

            if (wr_ctrl_s[i]) begin
                cont_d[i] = wd_s[1];
                ito_d[i]  = wd_s[0];
            end else begin
                cont_d[i] = cont_q[i];
                ito_d[i]  = ito_q[i];
            end

            // Snapshot takes the counter as it was before this cycle's update
            if (wr_snap_s[i]) begin
                snap_d[i] = cnt_q[i];
            end else begin
                snap_d[i] = snap_q[i];
            end

            if (wr_presc_s[i]) begin
                presc_d[i] = wd_s;
            end else begin
                presc_d[i] = presc_q[i];
            end
        end
    end

    // Read multiplexer; exactly one channel matches so the terms can be ORed.
    always_comb begin
        rdata_d = 16'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            logic [15:0] chan_rd;
            case (off_s)
                OFF_STATUS:  chan_rd = {14'd0, run_q[i], to_q[i]};
                OFF_CONTROL: chan_rd = {14'd0, cont_q[i], ito_q[i]};
                OFF_PER_L:   chan_rd = lo16(period_q[i]);
                OFF_PER_H:   chan_rd = hi16(period_q[i]);
                OFF_SNAP_L:  chan_rd = lo16(snap_q[i]);
                OFF_SNAP_H:  chan_rd = hi16(snap_q[i]);
                OFF_PRESC:   chan_rd = presc_q[i];
                OFF_PEND:    chan_rd = 16'(irq_vec);
                default:     chan_rd = 16'd0;
            endcase
            rdata_d = rdata_d | ((ch_s == AW'(i)) ? chan_rd : 16'd0);
        end
    end

    // State registers with asynchronous reset to the power-on values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= CNT_W'(DEF_PERIOD);
                cnt_q[i]    <= CNT_W'(DEF_PERIOD);
                snap_q[i]   <= {CNT_W{1'b0}};
                presc_q[i]  <= 16'd0;
                pcnt_q[i]   <= 16'd0;
            end
            run_q   <= {NUM_CH{1'b0}};
            to_q    <= {NUM_CH{1'b0}};
            cont_q  <= {NUM_CH{1'b0}};
            ito_q   <= {NUM_CH{1'b0}};
            rdata_q <= 16'd0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            run_q    <= run_d;
            to_q     <= to_d;
            cont_q   <= cont_d;
            ito_q    <= ito_d;
            rdata_q  <= rdata_d;
        end
    end

    // Interrupt outputs decoded straight from the flag registers.
    always_comb begin
        irq_vec = to_q & ito_q;
        irq     = |irq_vec;
    end

    assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_avl_multi_timer.sv
module tb_avl_multi_timer;

    logic       clk;
    logic       reset_n;
    logic       irq;
    logic [3:0] irq_vec;
    logic       irq16;
    logic [0:0] irq_vec16;

    avl_multi_timer_if #(.CH_BITS(2)) bus   ();
    avl_multi_timer_if #(.CH_BITS(0)) bus16 ();

    avl_multi_timer #(.CH_BITS(2), .CNT_W(32), .DEF_PERIOD(24999)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .irq     (irq),
        .irq_vec (irq_vec)
    );

    avl_multi_timer #(.CH_BITS(0), .CNT_W(16), .DEF_PERIOD(24999)) dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus16),
        .irq     (irq16),
        .irq_vec (irq_vec16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        bit          w16;
        bit          do_wr;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic [7:0]  ra;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.chipselect   = 1'b0;
        bus.write_n      = 1'b1;
        bus16.chipselect = 1'b0;
        bus16.write_n    = 1'b1;
    endtask

    task automatic drive(input bit w16, input logic [7:0] a, input bit is_wr, input logic [15:0] d);
        if (w16) begin
            bus16.address    = 3'(a);
            bus16.chipselect = 1'b1;
            bus16.write_n    = ~is_wr;
            bus16.writedata  = d;
        end else begin
            bus.address    = 5'(a);
            bus.chipselect = 1'b1;
            bus.write_n    = ~is_wr;
            bus.writedata  = d;
        end
    endtask

    task automatic wr(input bit w16, input logic [7:0] a, input logic [15:0] d);
        drive(w16, a, 1'b1, d);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input bit w16, input logic [7:0] a, input logic [15:0] exp, input string name);
        sb_t it;
        drive(w16, a, 1'b0, 16'h0000);
        sbq.push_back('{name, exp});
        @(posedge clk);
        #1;
        idle();
        it = sbq.pop_front();
        chk(it.name, w16 ? bus16.readdata : bus.readdata, it.exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 8'd0,  16'h0000, 8'd2,  16'd24999, "rst_per_l"};
        vecs[1]  = '{1'b0, 1'b0, 8'd0,  16'h0000, 8'd3,  16'h0000,  "rst_per_h"};
        vecs[2]  = '{1'b0, 1'b0, 8'd0,  16'h0000, 8'd0,  16'h0000,  "rst_status"};
        vecs[3]  = '{1'b0, 1'b0, 8'd0,  16'h0000, 8'd1,  16'h0000,  "rst_ctrl"};
        vecs[4]  = '{1'b0, 1'b0, 8'd0,  16'h0000, 8'd6,  16'h0000,  "rst_presc"};
        vecs[5]  = '{1'b0, 1'b0, 8'd0,  16'h0000, 8'd7,  16'h0000,  "rst_pend"};
        vecs[6]  = '{1'b0, 1'b0, 8'd0,  16'h0000, 8'd28, 16'h0000,  "rst_snap3"};
        vecs[7]  = '{1'b1, 1'b0, 8'd0,  16'h0000, 8'd2,  16'd24999, "rst16_per_l"};
        vecs[8]  = '{1'b0, 1'b1, 8'd30, 16'h1234, 8'd30, 16'h1234,  "presc_rw"};
        vecs[9]  = '{1'b0, 1'b1, 8'd27, 16'hABCD, 8'd27, 16'hABCD,  "per_h_rw"};
        vecs[10] = '{1'b0, 1'b1, 8'd28, 16'h0000, 8'd29, 16'hABCD,  "snap_h_loaded"};
        vecs[11] = '{1'b0, 1'b0, 8'd0,  16'h0000, 8'd28, 16'h61A7,  "snap_l_loaded"};
        vecs[12] = '{1'b0, 1'b1, 8'd25, 16'h0003, 8'd25, 16'h0003,  "ctrl_rw"};
        vecs[13] = '{1'b0, 1'b1, 8'd25, 16'h0030, 8'd25, 16'h0000,  "ctrl_hi_ign"};
        vecs[14] = '{1'b0, 1'b1, 8'd27, 16'h0000, 8'd27, 16'h0000,  "per_h_clr"};
        vecs[15] = '{1'b0, 1'b1, 8'd30, 16'h0000, 8'd30, 16'h0000,  "presc_clr"};
        vecs[16] = '{1'b1, 1'b1, 8'd3,  16'hFFFF, 8'd3,  16'h0000,  "w16_per_h"};
        vecs[17] = '{1'b1, 1'b0, 8'd0,  16'h0000, 8'd2,  16'd24999, "w16_per_l_kept"};
        vecs[18] = '{1'b1, 1'b1, 8'd2,  16'hFFFF, 8'd2,  16'hFFFF,  "w16_per_l"};
        vecs[19] = '{1'b1, 1'b1, 8'd4,  16'h0000, 8'd5,  16'h0000,  "w16_snap_h"};
        vecs[20] = '{1'b1, 1'b0, 8'd0,  16'h0000, 8'd4,  16'hFFFF,  "w16_snap_l"};

        bus.address     = 5'd0;
        bus.writedata   = 16'h0000;
        bus16.address   = 3'd0;
        bus16.writedata = 16'h0000;
        idle();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        // Before any clock edge
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_irq_vec", 32'(irq_vec), 32'd0);
        chk("rst_rdata", 32'(bus.readdata), 32'd0);
        chk("rst_irq16", 32'(irq16), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int k = 0; k < 21; k++) begin
            if (vecs[k].do_wr) wr(vecs[k].w16, vecs[k].wa, vecs[k].wd);
            rd(vecs[k].w16, vecs[k].ra, vecs[k].exp, vecs[k].name);
        end

        // Continuous channel 1: period 9, presc 0 -> timeout every 10 clocks
        wr(1'b0, 8'd10, 16'd9);
        wr(1'b0, 8'd11, 16'd0);
        wr(1'b0, 8'd14, 16'd0);
        wr(1'b0, 8'd9,  16'h0007);
        cycles(9);
        chk("cont_pre_to", 32'(irq_vec[1]), 32'd0);
        cycles(1);
        chk("cont_to1", 32'(irq_vec[1]), 32'd1);
        chk("cont_irq", 32'(irq), 32'd1);
        wr(1'b0, 8'd8, 16'h0000);
        chk("cont_clr", 32'(irq_vec[1]), 32'd0);
        chk("cont_irq_clr", 32'(irq), 32'd0);
        cycles(8);
        chk("cont_pre_to2", 32'(irq_vec[1]), 32'd0);
        cycles(1);
        chk("cont_to2", 32'(irq_vec[1]), 32'd1);
        // Clear lands exactly in the next timeout cycle: flag must survive
        cycles(9);
        wr(1'b0, 8'd8, 16'h0000);
        chk("to_vs_clr", 32'(irq_vec[1]), 32'd1);
        rd(1'b0, 8'd8, 16'h0003, "cont_status");
        wr(1'b0, 8'd9, 16'h0008);
        wr(1'b0, 8'd8, 16'h0000);
        rd(1'b0, 8'd8, 16'h0000, "stop_status");

        // One-shot channel 2: period 3, presc 4 -> single timeout after 20 clocks
        wr(1'b0, 8'd18, 16'd3);
        wr(1'b0, 8'd19, 16'd0);
        wr(1'b0, 8'd22, 16'd4);
        wr(1'b0, 8'd17, 16'h0005);
        cycles(19);
        chk("os_pre_to", 32'(irq_vec[2]), 32'd0);
        cycles(1);
        chk("os_to", 32'(irq_vec[2]), 32'd1);
        rd(1'b0, 8'd16, 16'h0001, "os_status");
        wr(1'b0, 8'd20, 16'h0000);
        rd(1'b0, 8'd20, 16'd3, "os_snap_l");
        rd(1'b0, 8'd21, 16'd0, "os_snap_h");

        // START and STOP together, then period write while running
        wr(1'b0, 8'd16, 16'h0000);
        wr(1'b0, 8'd17, 16'h000C);
        rd(1'b0, 8'd16, 16'h0002, "start_stop");
        wr(1'b0, 8'd18, 16'd6);
        rd(1'b0, 8'd16, 16'h0000, "per_wr_run");
        wr(1'b0, 8'd20, 16'h0000);
        rd(1'b0, 8'd20, 16'd6, "per_wr_cnt");

        // Multi-channel: ch0 period 5, ch3 period 7
        wr(1'b0, 8'd2,  16'd5);
        wr(1'b0, 8'd3,  16'd0);
        wr(1'b0, 8'd26, 16'd7);
        wr(1'b0, 8'd27, 16'd0);
        wr(1'b0, 8'd1,  16'h0007);
        cycles(6);
        rd(1'b0, 8'd7, 16'h0001, "pend_ch0");
        wr(1'b0, 8'd25, 16'h0007);
        cycles(8);
        wr(1'b0, 8'd1,  16'h000B);
        wr(1'b0, 8'd25, 16'h000B);
        rd(1'b0, 8'd15, 16'h0009, "pend_both");
        chk("irq_both", 32'(irq), 32'd1);
        wr(1'b0, 8'd0, 16'h0000);
        rd(1'b0, 8'd23, 16'h0008, "pend_ch3");
        chk("irq_ch3", 32'(irq), 32'd1);
        wr(1'b0, 8'd24, 16'h0000);
        rd(1'b0, 8'd31, 16'h0000, "pend_none");
        chk("irq_none", 32'(irq), 32'd0);

        // 16-bit counter: snapshot after 100 ticks, then full 65536-tick timeout
        wr(1'b1, 8'd1, 16'h0004);
        cycles(100);
        wr(1'b1, 8'd4, 16'h0000);
        rd(1'b1, 8'd4, 16'd65435, "w16_snap_run");
        rd(1'b1, 8'd5, 16'h0000, "w16_snap_h_run");
        wr(1'b1, 8'd2, 16'hFFFF);
        wr(1'b1, 8'd1, 16'h0005);
        cycles(65535);
        chk("w16_pre_to", 32'(irq_vec16), 32'd0);
        cycles(1);
        chk("w16_to", 32'(irq_vec16), 32'd1);
        chk("w16_irq", 32'(irq16), 32'd1);

        // Reset in the middle of a count
        wr(1'b0, 8'd9, 16'h0007);
        cycles(10);
        chk("pre_reset_irq", 32'(irq), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_irq", 32'(irq), 32'd0);
        chk("async_rst_vec", 32'(irq_vec), 32'd0);
        chk("async_rst_rdata", 32'(bus.readdata), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        rd(1'b0, 8'd10, 16'd24999, "post_rst_per");
        rd(1'b0, 8'd8, 16'h0000, "post_rst_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
